// File: rtl/pc_unit.sv
// pc_unit
// Program counter for the MIPS fetch stage. Holds the fetch address and
// moves it forward by INC bytes, or loads a branch/jump target, whenever
// the debug state machine allows it and the hazard unit is not stalling.
// A redirect always lands even while stalled, because a flush must not be lost.
// A halt freezes the unit until reset.
// All state changes on the falling edge of i_clk.
//
// Ports:
//   i_clk          clock, falling-edge active
//   i_rst          synchronous reset, active-low
//   i_stall        hazard stall, holds the PC
//   i_redirect     load i_redirect_pc instead of incrementing
//   i_redirect_pc  branch/jump target (LEN bits)
//   i_mode         0 = continuous run, 1 = single-step debug
//   i_step         step request (level; rising edge starts one step)
//   i_halt         halt instruction seen, freezes the unit until reset
//   o_pc           current PC (LEN bits)
//   o_adv          PC will update at the next falling edge (combinational)
//   o_state        debug FSM state: RUN=00, WAIT_STEP=01, STEP=10, HALT=11
//   o_count        saturating count of PC updates since reset (CNT_W bits)
module pc_unit #(
  parameter int LEN       = 32,
  parameter int INC       = 4,
  parameter int RESET_VEC = 0,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [LEN-1:0]   i_redirect_pc,
  input  logic             i_mode,
  input  logic             i_step,
  input  logic             i_halt,
  output logic [LEN-1:0]   o_pc,
  output logic             o_adv,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    WAIT_STEP = 2'b01,
    STEP      = 2'b10,
    HALT      = 2'b11
  } state_t;

  localparam logic [LEN-1:0]   ResetPc = LEN'(RESET_VEC);
  localparam logic [LEN-1:0]   IncVal  = LEN'(INC);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [LEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_q;

  logic             step_pulse;
  logic             can_go;
  logic             adv;

  // A held-high i_step must produce only one step, so only its rising edge counts.
  assign step_pulse = i_step & ~step_q;
  assign can_go     = (state_q == RUN) | (state_q == STEP);
  // Halt beats everything; a redirect overrides a stall so flushes always land.
  assign adv        = can_go & ~i_halt & (i_redirect | ~i_stall);

  // Next PC, advance counter and debug FSM transitions.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    state_d = state_q;

    if (adv) begin
      pc_d = i_redirect ? i_redirect_pc : pc_q + IncVal;
      if (count_q != CntMax) begin
        count_d = count_q + CntOne;
      end
    end

    unique case (state_q)
      RUN: begin
        if (i_halt)      state_d = HALT;
        else if (i_mode) state_d = WAIT_STEP;
      end
      WAIT_STEP: begin
        if (i_halt)          state_d = HALT;
        else if (!i_mode)    state_d = RUN;
        else if (step_pulse) state_d = STEP;
      end
      STEP: begin
        // A stalled step stays pending; i_mode is not looked at until it completes.
        if (i_halt)   state_d = HALT;
        else if (adv) state_d = WAIT_STEP;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers; reset discards any pending step and picks the start
  // state from i_mode so a debug session can begin straight out of reset.
  always_ff @(negedge i_clk) begin
    if (!i_rst) begin
      pc_q    <= ResetPc;
      count_q <= '0;
      step_q  <= 1'b0;
      state_q <= i_mode ? WAIT_STEP : RUN;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      step_q  <= i_step;
      state_q <= state_d;
    end
  end

  assign o_pc    = pc_q;
  assign o_adv   = adv;
  assign o_state = state_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit
// Self-checking bench for pc_unit. Two instances share the control inputs:
// a 32-bit one with RESET_VEC=0x100, and a small one (LEN=8,
// RESET_VEC=0xF8, CNT_W=2) that stays in reset until the final phase
// and then shows PC wrap and counter saturation.
// Every cycle the bench model's expected outputs are queued when stimulus
// is driven and popped for comparison after the falling edge.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        stepQ;
  } model_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [31:0] pcS;
    logic [1:0]  stS;
    logic [31:0] cntS;
  } exp_t;

  logic        clk;
  logic        iRst, iRstS, iStall, iRedirect, iMode, iStep, iHalt;
  logic [31:0] iTarget;

  logic [31:0] oPc, oCount;
  logic        oAdv;
  logic [1:0]  oState;
  logic [7:0]  oPcS;
  logic        oAdvS;
  logic [1:0]  oStateS;
  logic [1:0]  oCountS;

  int          testsRun    = 0;
  int          testsFailed = 0;
  exp_t        expQ[$];
  model_t      mBig, mSm;

  pc_unit #(.LEN(32), .INC(4), .RESET_VEC(32'h100), .CNT_W(32)) dutBig (
    .i_clk(clk), .i_rst(iRst), .i_stall(iStall), .i_redirect(iRedirect),
    .i_redirect_pc(iTarget), .i_mode(iMode), .i_step(iStep), .i_halt(iHalt),
    .o_pc(oPc), .o_adv(oAdv), .o_state(oState), .o_count(oCount)
  );

  pc_unit #(.LEN(8), .INC(4), .RESET_VEC(8'hF8), .CNT_W(2)) dutSmall (
    .i_clk(clk), .i_rst(iRstS), .i_stall(iStall), .i_redirect(iRedirect),
    .i_redirect_pc(iTarget[7:0]), .i_mode(iMode), .i_step(iStep), .i_halt(iHalt),
    .o_pc(oPcS), .o_adv(oAdvS), .o_state(oStateS), .o_count(oCountS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic modelAdv(model_t m, logic stall, logic redir, logic halt);
    return ((m.st == 2'b00) || (m.st == 2'b10)) && !halt && (redir || !stall);
  endfunction

  // Reference behaviour written from the PC/FSM description, one edge at a time.
  function automatic model_t nextModel(model_t m, logic rst, logic stall, logic redir,
                                       logic [31:0] tgt, logic mode, logic step, logic halt,
                                       logic [31:0] rv, logic [31:0] pcMask, logic [31:0] cntMax);
    model_t n;
    logic   adv;
    n   = m;
    adv = modelAdv(m, stall, redir, halt);
    if (!rst) begin
      n.pc    = rv & pcMask;
      n.cnt   = 32'd0;
      n.stepQ = 1'b0;
      n.st    = mode ? 2'b01 : 2'b00;
      return n;
    end
    if (adv) begin
      n.pc = (redir ? tgt : m.pc + 32'd4) & pcMask;
      if (m.cnt != cntMax) n.cnt = m.cnt + 32'd1;
    end
    n.stepQ = step;
    case (m.st)
      2'b00:   if (halt) n.st = 2'b11; else if (mode) n.st = 2'b01;
      2'b01:   if (halt) n.st = 2'b11; else if (!mode) n.st = 2'b00;
               else if (step && !m.stepQ) n.st = 2'b10;
      2'b10:   if (halt) n.st = 2'b11; else if (adv) n.st = 2'b01;
      default: n.st = 2'b11;
    endcase
    return n;
  endfunction

  // Drive one cycle of inputs, queue the expected result, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic rstS, input logic stall,
                               input logic redir, input logic [31:0] tgt, input logic mode,
                               input logic step, input logic halt);
    exp_t e;
    @(posedge clk);
    iRst = rst; iRstS = rstS; iStall = stall; iRedirect = redir;
    iTarget = tgt; iMode = mode; iStep = step; iHalt = halt;
    #1;
    if (rst)  checkOutput("adv", {31'd0, oAdv}, {31'd0, modelAdv(mBig, stall, redir, halt)});
    if (rstS) checkOutput("advSmall", {31'd0, oAdvS}, {31'd0, modelAdv(mSm, stall, redir, halt)});
    mBig = nextModel(mBig, rst, stall, redir, tgt, mode, step, halt,
                     32'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mSm  = nextModel(mSm, rstS, stall, redir, tgt, mode, step, halt,
                     32'hF8, 32'h0000_00FF, 32'd3);
    e.pc = mBig.pc; e.st = mBig.st; e.cnt = mBig.cnt;
    e.pcS = mSm.pc; e.stS = mSm.st; e.cntS = mSm.cnt;
    expQ.push_back(e);
    @(negedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput("pc", oPc, e.pc);
      checkOutput("state", {30'd0, oState}, {30'd0, e.st});
      checkOutput("count", oCount, e.cnt);
      checkOutput("pcSmall", {24'd0, oPcS}, e.pcS);
      checkOutput("stateSmall", {30'd0, oStateS}, {30'd0, e.stS});
      checkOutput("countSmall", {30'd0, oCountS}, e.cntS);
    end
  endtask

  logic [7:0] smallPcExp [5]  = '{8'hFC, 8'h00, 8'h04, 8'h08, 8'h0C};
  logic [1:0] smallCntExp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    mBig = '0;
    mSm  = '0;
    iRst = 1'b0; iRstS = 1'b0; iStall = 1'b0; iRedirect = 1'b0;
    iTarget = 32'd0; iMode = 1'b0; iStep = 1'b0; iHalt = 1'b0;

    // Reset into RUN, then five free-running advances.
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("pcAfter5", oPc, 32'h114);
    checkOutput("countAfter5", oCount, 32'd5);
    checkOutput("stateRun", {30'd0, oState}, 32'd0);

    // Stall holds the PC; a redirect lands through the stall.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("pcStalled", oPc, 32'h114);
    applyStimulus(1, 0, 1, 1, 32'h400, 0, 0, 0);
    checkOutput("pcRedirect", oPc, 32'h400);
    checkOutput("countRedirect", oCount, 32'd6);

    // Single-step mode: held step gives one advance, stalled step completes later.
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("stateWaitStep", {30'd0, oState}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 32'h0, 1, 1, 0);
    checkOutput("pcOneStep", oPc, 32'h104);
    applyStimulus(1, 0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 32'h0, 1, 1, 0);
    checkOutput("stateStep", {30'd0, oState}, 32'd2);
    applyStimulus(1, 0, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("stepPending", {30'd0, oState}, 32'd2);
    applyStimulus(1, 0, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("pcSecondStep", oPc, 32'h108);
    checkOutput("stateBackWait", {30'd0, oState}, 32'd1);

    // Halt beats a coincident redirect; HALT ignores everything but reset.
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 32'h800, 0, 0, 1);
    checkOutput("pcHalted", oPc, 32'h108);
    checkOutput("stateHalt", {30'd0, oState}, 32'd3);
    applyStimulus(1, 0, 0, 1, 32'h800, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 32'h900, 0, 0, 0);
    checkOutput("pcStillHalted", oPc, 32'h108);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("pcAfterReset", oPc, 32'h100);
    checkOutput("countAfterReset", oCount, 32'd0);

    // Randomised control traffic checked against the model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 14) != 0), 0,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom & 32'hFFFF_FFFC), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1), ($urandom_range(0, 19) == 0));
    end

    // Small instance: PC wrap past 0xFF and 2-bit counter saturation.
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
      checkOutput("smallWrapPc", {24'd0, oPcS}, {24'd0, smallPcExp[i]});
      checkOutput("smallSatCount", {30'd0, oCountS}, {30'd0, smallCntExp[i]});
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
